uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_parity_calc.sv | 15 +
 rtl/uart_tx_frame.sv | 114 +++++++++++
 tb/tb_uart_tx_frame.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding, parity types and line levels.
// Used by both the TX frame engine and the RX path.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of the latched TX word.
// Even parity yields the XOR of the data bits; odd parity yields its inverse.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_o
);

  assign par_o = (par_typ_i == PAR_ODD) ? ~(^data_i) : (^data_i);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start bit, LSB-first data, optional parity, stop bit.
// One serial bit per CLK_TX cycle; outputs are registered and decoded from the next state.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK_TX,
  input  logic                  RST_TX,
  input  logic [DATA_WIDTH-1:0] P_DATA_TX,
  input  logic                  DATA_VALID_TX,
  input  logic                  PAR_EN_TX,
  input  logic                  PAR_TYP_TX,
  output logic                  TX_OUT_TX,
  output logic                  BUSY_TX
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_s;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data_i   (data_q),
    .par_typ_i(par_typ_q),
    .par_o    (par_s)
  );

  // Next-state logic; the request and frame settings are only sampled in IDLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    case (state_q)
      ST_IDLE: begin
        if (DATA_VALID_TX) begin
          state_d   = ST_START;
          data_d    = P_DATA_TX;
          par_en_d  = PAR_EN_TX;
          par_typ_d = PAR_TYP_TX;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = {CW{1'b0}};
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so the line changes right after the edge
  always_comb begin
    tx_d   = LINE_IDLE;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_IDLE:   tx_d = LINE_IDLE;
      ST_START:  tx_d = START_BIT;
      ST_DATA:   tx_d = data_q[cnt_d];
      ST_PARITY: tx_d = par_s;
      ST_STOP:   tx_d = STOP_BIT;
      default:   tx_d = LINE_IDLE;
    endcase
  end

  // State, counter, data latch and registered outputs
  always_ff @(posedge CLK_TX or negedge RST_TX) begin
    if (!RST_TX) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CW{1'b0}};
      data_q    <= {DATA_WIDTH{1'b0}};
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT_TX = tx_q;
  assign BUSY_TX   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with hand-computed serial frames.
// Outputs are sampled on the falling edge, inputs driven on the falling edge.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst_n;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int n_checks;
  int n_fail;

  uart_tx_frame #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK_TX       (clk),
    .RST_TX       (rst_n),
    .P_DATA_TX    (p_data),
    .DATA_VALID_TX(data_valid),
    .PAR_EN_TX    (par_en),
    .PAR_TYP_TX   (par_typ),
    .TX_OUT_TX    (tx_out),
    .BUSY_TX      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a one-cycle request; returns at the falling edge showing the start bit.
  task automatic drive_req(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Called while the start bit is on the line; walks the whole frame plus one idle cycle.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic exp_par);
    check_eq({tag, "_start"}, {31'd0, tx_out}, 32'd0);
    check_eq({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("%s_d%0d", tag, i), {31'd0, tx_out}, {31'd0, d[i]});
      check_eq($sformatf("%s_busy_d%0d", tag, i), {31'd0, busy}, 32'd1);
    end
    if (pe) begin
      @(negedge clk);
      check_eq({tag, "_par"}, {31'd0, tx_out}, {31'd0, exp_par});
      check_eq({tag, "_busy_par"}, {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check_eq({tag, "_stop"}, {31'd0, tx_out}, 32'd1);
    check_eq({tag, "_busy_stop"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq({tag, "_idle"}, {31'd0, tx_out}, 32'd1);
    check_eq({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", {31'd0, tx_out}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_tx", {31'd0, tx_out}, 32'd1);

    // 0xA5 LSB-first: 1,0,1,0,0,1,0,1; four ones so even parity is 0
    drive_req(8'hA5, 1'b0, 1'b0);
    check_frame("nopar_a5", 8'hA5, 1'b0, 1'b0);
    drive_req(8'hA5, 1'b1, 1'b0);
    check_frame("even_a5", 8'hA5, 1'b1, 1'b0);
    drive_req(8'h01, 1'b1, 1'b1);
    check_frame("odd_01", 8'h01, 1'b1, 1'b0);
    drive_req(8'h00, 1'b1, 1'b1);
    check_frame("odd_00", 8'h00, 1'b1, 1'b1);

    // Request and setting changes during DATA must not disturb the frame in flight
    drive_req(8'hA5, 1'b0, 1'b0);
    check_eq("ign_start", {31'd0, tx_out}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("ign_d%0d", i), {31'd0, tx_out}, {31'd0, 8'hA5 >> i} & 32'd1);
      if (i == 2) begin
        data_valid = 1'b1;
        p_data     = 8'h3C;
        par_en     = 1'b1;
      end else if (i == 3) begin
        data_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("ign_stop", {31'd0, tx_out}, 32'd1);
    check_eq("ign_busy_stop", {31'd0, busy}, 32'd1);
    par_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("ign_idle%0d", i), {31'd0, tx_out}, 32'd1);
      check_eq($sformatf("ign_busy_idle%0d", i), {31'd0, busy}, 32'd0);
    end

    // Held request: back-to-back frames with exactly one idle cycle between them
    @(negedge clk);
    p_data     = 8'h81;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    check_frame("hold1", 8'h81, 1'b0, 1'b0);
    @(negedge clk);
    data_valid = 1'b0;
    check_frame("hold2", 8'h81, 1'b0, 1'b0);

    // Reset after the 4th data bit clears the frame immediately
    drive_req(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("pre_rst_d3", {31'd0, tx_out}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_tx", {31'd0, tx_out}, 32'd1);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("postrst_tx", {31'd0, tx_out}, 32'd1);
    check_eq("postrst_busy", {31'd0, busy}, 32'd0);
    drive_req(8'h5A, 1'b0, 1'b0);
    check_frame("after_rst_5a", 8'h5A, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
